// File: rtl/envelope_pkg.sv
// Shared types and constants for the envelope follower: gate FSM states and
// the largest representable envelope value for a given sample width.
package envelope_pkg;

    typedef enum logic [1:0] {
        GATE_OFF  = 2'd0,
        GATE_ON   = 2'd1,
        GATE_HOLD = 2'd2
    } gate_state_e;

    // Largest magnitude of a signed sample; -2^(W-1) is clamped to this.
    function automatic logic [63:0] env_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    localparam logic [63:0] ENV_MAX = env_max(24);

endpackage

// File: rtl/envelope_slew_step.sv
// One envelope slew step: move env toward abs by (|abs-env| >> shift),
// never less than 1, never overshooting abs.
module envelope_slew_step #(
    parameter int DATA_WIDTH = 24
) (
    input  logic [DATA_WIDTH-1:0] i_abs,
    input  logic [DATA_WIDTH-1:0] i_env,
    input  logic [4:0]            i_shift,
    output logic [DATA_WIDTH-1:0] o_env_next
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_step;

    // Magnitude of the error, shifted step with a floor of one LSB.
    always_comb begin
        w_diff = '0;
        w_step = '0;
        if (i_abs > i_env) begin
            w_diff = i_abs - i_env;
        end else begin
            w_diff = i_env - i_abs;
        end
        w_step = w_diff >> i_shift;
        if (w_step == '0) begin
            w_step = ONE;
        end else begin
            w_step = w_step;
        end
    end

    // Step toward abs; diff <= step floor only when diff is already 1, so no overshoot.
    always_comb begin
        o_env_next = i_env;
        if (w_diff == '0) begin
            o_env_next = i_env;
        end else if (i_abs > i_env) begin
            o_env_next = i_env + w_step;
        end else begin
            o_env_next = i_env - w_step;
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// Rectify -> attack/release slewed envelope -> hysteresis gate with hold.
// Capture, rectify and update registers stall together under backpressure.
module envelope_follower
    import envelope_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int HOLD_SAMPLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] signal_i,
    input  logic [4:0]            attack_shift_i,
    input  logic [4:0]            release_shift_i,
    input  logic [DATA_WIDTH-1:0] gate_on_thresh_i,
    input  logic [DATA_WIDTH-1:0] gate_off_thresh_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] envelope_o,
    output logic                  gate_o
);

    localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [DATA_WIDTH-1:0] W_ENV_MAX = DATA_WIDTH'(env_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] W_MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] W_ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      W_HOLD    = CNT_W'(HOLD_SAMPLES);

    logic                  r_in_valid;
    logic [DATA_WIDTH-1:0] r_in_sample;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_abs;
    logic [DATA_WIDTH-1:0] r_env;
    gate_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_advance;
    logic [DATA_WIDTH-1:0] w_abs;
    logic [4:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_env_next;
    gate_state_e           w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      w_cnt_inc;

    assign w_advance  = ~(valid_o & ~ready_i);
    assign ready_o    = ~rst_i & w_advance;
    assign envelope_o = r_env;
    assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Rectify the captured sample, clamping the most negative code.
    always_comb begin
        w_abs = r_in_sample;
        if (r_in_sample == W_MIN_NEG) begin
            w_abs = W_ENV_MAX;
        end else if (r_in_sample[DATA_WIDTH-1]) begin
            w_abs = ~r_in_sample + W_ONE;
        end else begin
            w_abs = r_in_sample;
        end
    end

    // Rising input uses the attack rate, falling uses release.
    always_comb begin
        w_shift = release_shift_i;
        if (r_s1_abs > r_env) begin
            w_shift = attack_shift_i;
        end else begin
            w_shift = release_shift_i;
        end
    end

    envelope_slew_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slew (
        .i_abs      (r_s1_abs),
        .i_env      (r_env),
        .i_shift    (w_shift),
        .o_env_next (w_env_next)
    );

    // Gate next-state on the freshly updated envelope; counter counts hold updates.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            GATE_OFF: begin
                if (w_env_next > gate_on_thresh_i) begin
                    w_state_next = GATE_ON;
                end else begin
                    w_state_next = GATE_OFF;
                end
            end
            GATE_ON: begin
                if (w_env_next < gate_off_thresh_i) begin
                    w_state_next = GATE_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = GATE_ON;
                end
            end
            GATE_HOLD: begin
                if (w_env_next > gate_on_thresh_i) begin
                    w_state_next = GATE_ON;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc >= W_HOLD) begin
                    w_state_next = GATE_OFF;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = GATE_OFF;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Gate FSM state and hold counter, advanced once per envelope update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= GATE_OFF;
            r_cnt   <= '0;
        end else if (w_advance && r_s1_valid) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end else begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end
    end

    // Capture and rectify stages; both freeze while the output is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_valid  <= 1'b0;
            r_in_sample <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_abs    <= '0;
        end else if (w_advance) begin
            r_in_valid  <= valid_i;
            r_in_sample <= valid_i ? signal_i : r_in_sample;
            r_s1_valid  <= r_in_valid;
            r_s1_abs    <= r_in_valid ? w_abs : r_s1_abs;
        end else begin
            r_in_valid  <= r_in_valid;
            r_in_sample <= r_in_sample;
            r_s1_valid  <= r_s1_valid;
            r_s1_abs    <= r_s1_abs;
        end
    end

    // Output/envelope register: envelope_o doubles as the envelope state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            r_env   <= '0;
            gate_o  <= 1'b0;
        end else if (w_advance) begin
            valid_o <= r_s1_valid;
            r_env   <= r_s1_valid ? w_env_next : r_env;
            gate_o  <= r_s1_valid ? (w_state_next != GATE_OFF) : gate_o;
        end else begin
            valid_o <= valid_o;
            r_env   <= r_env;
            gate_o  <= gate_o;
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Randomized + directed scoreboard bench for envelope_follower with a
// plain-arithmetic reference model of the envelope and gate.
module tb_envelope_follower;

    localparam int DW = 24;
    localparam int HS = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] signal_i;
    logic [4:0]    attack_shift_i;
    logic [4:0]    release_shift_i;
    logic [DW-1:0] gate_on_thresh_i;
    logic [DW-1:0] gate_off_thresh_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] envelope_o;
    logic          gate_o;

    envelope_follower #(.DATA_WIDTH(DW), .HOLD_SAMPLES(HS)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .signal_i          (signal_i),
        .attack_shift_i    (attack_shift_i),
        .release_shift_i   (release_shift_i),
        .gate_on_thresh_i  (gate_on_thresh_i),
        .gate_off_thresh_i (gate_off_thresh_i),
        .ready_i           (ready_i),
        .valid_o           (valid_o),
        .envelope_o        (envelope_o),
        .gate_o            (gate_o)
    );

    always #5 clk = ~clk;

    typedef struct { longint env; bit gate; } exp_t;
    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    int     stall_req = 0;
    bit     rand_rdy = 1'b0;

    // reference model state
    longint m_env;
    bit     m_on, m_hold;
    int     m_left;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_env = 0; m_on = 1'b0; m_hold = 1'b0; m_left = 0;
    endfunction

    function automatic exp_t model_step(input longint x);
        longint a, d, st, on_t, off_t;
        exp_t e;
        on_t  = longint'(gate_on_thresh_i);
        off_t = longint'(gate_off_thresh_i);
        a = (x < 0) ? -x : x;
        if (a > 8388607) a = 8388607;
        if (a > m_env) begin
            d = a - m_env; st = d >> attack_shift_i; if (st < 1) st = 1; m_env = m_env + st;
        end else if (a < m_env) begin
            d = m_env - a; st = d >> release_shift_i; if (st < 1) st = 1; m_env = m_env - st;
        end
        if (m_hold) begin
            if (m_env > on_t) begin
                m_hold = 1'b0; m_on = 1'b1;
            end else begin
                m_left--;
                if (m_left == 0) m_hold = 1'b0;
            end
        end else if (m_on) begin
            if (m_env < off_t) begin
                m_on = 1'b0; m_hold = 1'b1; m_left = HS;
            end
        end else if (m_env > on_t) begin
            m_on = 1'b1;
        end
        e.env  = m_env;
        e.gate = m_on || m_hold;
        return e;
    endfunction

    task automatic send(input longint x, input bit use_c = 1'b0,
                        input longint c_env = 0, input bit c_gate = 1'b0);
        int   n;
        exp_t e;
        @(negedge clk);
        signal_i = x[DW-1:0];
        valid_i  = 1'b1;
        n = 0;
        while (!ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("accept_timeout", 0, 1);
            valid_i = 1'b0;
        end else begin
            e = model_step(x);
            if (use_c) begin
                e.env  = c_env;
                e.gate = c_gate;
            end
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || valid_o) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready_o"}, ready_o, 0);
        chk({tag, "_valid_o"}, valid_o, 0);
        chk({tag, "_envelope_o"}, envelope_o, 0);
        chk({tag, "_gate_o"}, gate_o, 0);
    endtask

    // ready_i driver: forced 5-cycle stalls on request, otherwise 1 or random
    initial begin : rdy_drv
        int seen, left;
        seen = 0; left = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req != seen) begin
                seen = stall_req;
                left = 5;
            end
            if (left > 0) begin
                ready_i = 1'b0;
                left--;
            end else begin
                ready_i = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // monitor: scoreboard pops on transfer, stall stability checks
    initial begin : mon
        bit            prev_stall;
        logic [DW-1:0] h_env;
        logic          h_gate;
        exp_t          e;
        prev_stall = 1'b0;
        h_env = '0;
        h_gate = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", valid_o, 1);
                    chk("stall_env_hold", envelope_o, h_env);
                    chk("stall_gate_hold", gate_o, h_gate);
                end
                if (valid_o && !ready_i) begin
                    chk("stall_ready_o", ready_o, 0);
                    prev_stall = 1'b1;
                    h_env  = envelope_o;
                    h_gate = gate_o;
                end else begin
                    prev_stall = 1'b0;
                end
                if (valid_o && ready_i) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("envelope", envelope_o, e.env);
                        chk("gate", gate_o, e.gate);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    longint d_in[15] = '{5000, 0, 0, 0, 0, 0, 5000, 0, 0, 5000, 0, 0, 0, 0, 0};
    bit     d_g[15]  = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin : main
        longint t0;
        int     n;
        logic signed [DW-1:0] rs;
        rst_i = 1'b1; valid_i = 1'b0; signal_i = '0;
        attack_shift_i = 5'd0; release_shift_i = 5'd0;
        gate_on_thresh_i = 24'hFFFFFF; gate_off_thresh_i = 24'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2; rst_i = 1'b0;

        // instant attack with latency measurement
        send(1048576, 1'b1, 1048576, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        t0 = cyc;
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - t0, 2);
        drain();

        // slewed attack then release
        send(0, 1'b1, 0, 1'b0);
        drain();
        attack_shift_i = 5'd1;
        send(1000, 1'b1, 500, 1'b0);
        send(1000, 1'b1, 750, 1'b0);
        send(1000, 1'b1, 875, 1'b0);
        send(1000, 1'b1, 937, 1'b0);
        drain();
        release_shift_i = 5'd3;
        send(0, 1'b1, 820, 1'b0);
        drain();

        // saturation of most negative code
        attack_shift_i = 5'd0;
        send(-8388608, 1'b1, 8388607, 1'b0);
        send(8388607, 1'b1, 8388607, 1'b0);
        drain();

        // gate hysteresis, hold and retrigger
        release_shift_i = 5'd0;
        gate_on_thresh_i = 24'd4000;
        gate_off_thresh_i = 24'd2000;
        for (int i = 0; i < 15; i++) send(d_in[i], 1'b1, d_in[i], d_g[i]);
        drain();

        // backpressure on a ramp
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) stall_req++;
            send(longint'(i) * 1000);
        end
        drain();

        // reset mid-stream
        gate_on_thresh_i = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) send(longint'($urandom_range(100000, 900000)));
        @(posedge clk); #2;
        rst_i = 1'b1;
        valid_i = 1'b0;
        q.delete();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("midreset");
        end
        @(posedge clk); #2; rst_i = 1'b0;
        send(1000, 1'b1, 1000, 1'b0);
        drain();

        // randomized traffic with random controls and random ready_i
        rand_rdy = 1'b1;
        for (int b = 0; b < 8; b++) begin
            drain();
            attack_shift_i  = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(4));
            release_shift_i = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(4));
            gate_on_thresh_i  = DW'($urandom_range(8388608));
            gate_off_thresh_i = DW'($urandom_range(8388608));
            for (int k = 0; k < 25; k++) begin
                rs = DW'($urandom);
                send(longint'(rs));
            end
        end
        rand_rdy = 1'b0;
        drain();
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
